// File: rtl/btn_conditioner.sv
// btn_conditioner: keypad input conditioner.
// Synchronises four raw push-buttons, debounces them and merges one physical
// press (single key or chord) into a single-cycle code pulse on btn_pulse.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | keys released and quiet; waiting for any key
// ST_SETTLE  | key(s) down; accumulating chord, waiting for a stable window
// ST_HELD    | press accepted and pulsed; waiting for all keys to release
// ST_RELEASE | keys released; waiting for a quiet window before re-arming
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_pulse,
  output logic       pressed,
  output logic       ready
);

  localparam int unsigned      CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  // Sync flops reset to the released pin level so reset never looks like a press.
  localparam logic [3:0]       RELEASED_LVL = ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [3:0]       cap_q,    cap_d;
  logic [3:0]       pulse_q,  pulse_d;
  logic [3:0]       sync1_q,  sync1_d;
  logic [3:0]       sync2_q,  sync2_d;
  logic [3:0]       s_prev_q, s_prev_d;

  logic [3:0]       s;
  logic             s_any;
  logic             s_changed;
  logic             cnt_done;

  // Two-flop synchroniser chain and one-cycle history of the sampled vector.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    s_prev_d = s;
  end

  // Polarity fix: s is 1 for a pressed key regardless of pin polarity.
  always_comb begin
    s         = ACTIVE_LOW ? ~sync2_q : sync2_q;
    s_any     = (s != 4'b0000);
    s_changed = (s != s_prev_q);
    cnt_done  = (cnt_q == CNT_LAST);
  end

  // State register and datapath flops, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cap_q    <= 4'b0000;
      pulse_q  <= 4'b0000;
      sync1_q  <= RELEASED_LVL;
      sync2_q  <= RELEASED_LVL;
      s_prev_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      pulse_q  <= pulse_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      s_prev_q <= s_prev_d;
    end
  end

  // Next-state logic: window counter, chord accumulation and pulse capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    pulse_d = 4'b0000;
    unique case (state_q)
      ST_IDLE: begin
        if (s_any) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          cap_d   = s;
        end
      end
      ST_SETTLE: begin
        if (!s_any) begin
          // Everything let go before the window closed: treat as a glitch.
          state_d = ST_IDLE;
          cnt_d   = '0;
          cap_d   = 4'b0000;
        end else if (s_changed) begin
          // Released keys stay in the chord; any change restarts the window.
          cap_d = cap_q | s;
          cnt_d = '0;
        end else if (cnt_done) begin
          state_d = ST_HELD;
          pulse_d = cap_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!s_any) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (s_any) begin
          // Release bounce: go back to waiting, never a new press.
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          cap_d   = 4'b0000;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        cap_d   = 4'b0000;
      end
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    btn_pulse = pulse_q;
    pressed   = (state_q == ST_SETTLE) || (state_q == ST_HELD);
    ready     = (state_q == ST_IDLE);
  end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_pulse;
  logic       pressed;
  logic       ready;

  int n_checks = 0;
  int n_fail   = 0;

  btn_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_pulse (btn_pulse),
    .pressed   (pressed),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  // Reference model: the key vector seen by the debouncer is the pin value
  // from two edges back. A press is a run of non-zero vectors; it is accepted
  // once the vector has been unchanged for D edges, and re-arming needs D
  // consecutive all-zero edges after the press ends.
  logic [3:0] h1 = 0, h2 = 0, h3 = 0;
  logic [3:0] m_s, m_s_before;
  int         m_mode = 0;          // 0 waiting, 1 settling, 2 accepted, 3 quiet check
  int         m_run = 0;
  logic [3:0] m_chord = 0;
  logic [3:0] m_pulse = 0;
  bit         m_pressed = 0;
  bit         m_ready = 1;

  always @(posedge clk) begin
    m_pulse = 4'b0000;
    if (rst) begin
      h1 = 0; h2 = 0; h3 = 0;
      m_mode = 0; m_run = 0; m_chord = 0;
    end else begin
      m_s = h2;
      m_s_before = h3;
      if (m_mode == 0) begin
        if (m_s != 0) begin m_mode = 1; m_chord = m_s; m_run = 0; end
      end else if (m_mode == 1) begin
        if (m_s == 0) begin m_mode = 0; m_chord = 0; end
        else if (m_s != m_s_before) begin m_chord = m_chord | m_s; m_run = 0; end
        else begin
          m_run = m_run + 1;
          if (m_run == D) begin m_pulse = m_chord; m_mode = 2; end
        end
      end else if (m_mode == 2) begin
        if (m_s == 0) begin m_mode = 3; m_run = 0; end
      end else begin
        if (m_s != 0) m_mode = 2;
        else begin
          m_run = m_run + 1;
          if (m_run == D) begin m_mode = 0; m_chord = 0; end
        end
      end
      h3 = h2; h2 = h1; h1 = btn_raw;
    end
    m_pressed = (m_mode == 1) || (m_mode == 2);
    m_ready   = (m_mode == 0);
  end

  task automatic tick(input logic [3:0] raw);
    btn_raw = raw;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(4'b0000);
    tick(4'b0000);
    n_checks++;
    if (btn_pulse !== 4'b0000 || ready !== 1'b1 || pressed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values got pulse=%b ready=%b pressed=%b want 0000/1/0", btn_pulse, ready, pressed);
    end
    rst = 1'b0;
    tick(4'b0000);
    n_checks++;
    if ({btn_pulse, pressed, ready} !== {m_pulse, m_pressed, m_ready}) begin
      n_fail++;
      $display("FAIL reset_model got %b/%b/%b want %b/%b/%b", btn_pulse, pressed, ready, m_pulse, m_pressed, m_ready);
    end
  endtask

  task automatic test_clean_press();
    for (int i = 1; i <= 12; i++) begin
      tick(4'b0111);
      n_checks++;
      if (btn_pulse !== ((i == 7) ? 4'b0111 : 4'b0000)) begin
        n_fail++;
        $display("FAIL clean_pulse tick=%0d got %b want %b", i, btn_pulse, (i == 7) ? 4'b0111 : 4'b0000);
      end
      n_checks++;
      if (pressed !== (i >= 3)) begin
        n_fail++;
        $display("FAIL clean_pressed tick=%0d got %b want %b", i, pressed, (i >= 3));
      end
    end
    for (int i = 1; i <= 10; i++) begin
      tick(4'b0000);
      n_checks++;
      if ({btn_pulse, pressed, ready} !== {m_pulse, m_pressed, m_ready}) begin
        n_fail++;
        $display("FAIL clean_release tick=%0d got %b/%b/%b want %b/%b/%b", i, btn_pulse, pressed, ready, m_pulse, m_pressed, m_ready);
      end
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_rearm got ready=%b want 1", ready);
    end
  endtask

  task automatic test_glitch();
    for (int i = 1; i <= 11; i++) begin
      tick((i <= 3) ? 4'b0010 : 4'b0000);
      n_checks++;
      if (btn_pulse !== 4'b0000 || {pressed, ready} !== {m_pressed, m_ready}) begin
        n_fail++;
        $display("FAIL glitch tick=%0d got %b/%b/%b want 0000/%b/%b", i, btn_pulse, pressed, ready, m_pressed, m_ready);
      end
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_ready got %b want 1", ready);
    end
  endtask

  task automatic test_chord();
    for (int i = 1; i <= 12; i++) begin
      tick((i <= 2) ? 4'b0001 : 4'b1101);
      n_checks++;
      if (btn_pulse !== ((i == 9) ? 4'b1101 : 4'b0000)) begin
        n_fail++;
        $display("FAIL chord_pulse tick=%0d got %b want %b", i, btn_pulse, (i == 9) ? 4'b1101 : 4'b0000);
      end
    end
    for (int i = 1; i <= 10; i++) begin
      tick(4'b0000);
      n_checks++;
      if ({btn_pulse, pressed, ready} !== {m_pulse, m_pressed, m_ready}) begin
        n_fail++;
        $display("FAIL chord_release tick=%0d got %b/%b/%b want %b/%b/%b", i, btn_pulse, pressed, ready, m_pulse, m_pressed, m_ready);
      end
    end
  endtask

  task automatic test_release_bounce();
    int pulses = 0;
    logic [3:0] pat;
    for (int i = 1; i <= 14; i++) begin
      pat = (i <= 10 || i >= 13) ? 4'b0001 : 4'b0000;
      tick(pat);
      if (btn_pulse != 0) pulses++;
      n_checks++;
      if ({btn_pulse, pressed, ready} !== {m_pulse, m_pressed, m_ready}) begin
        n_fail++;
        $display("FAIL bounce_model tick=%0d got %b/%b/%b want %b/%b/%b", i, btn_pulse, pressed, ready, m_pulse, m_pressed, m_ready);
      end
    end
    for (int i = 1; i <= 10; i++) begin
      tick(4'b0000);
      if (btn_pulse != 0) pulses++;
      if (i == 6 || i == 7) begin
        n_checks++;
        if (ready !== (i == 7)) begin
          n_fail++;
          $display("FAIL bounce_ready tick=%0d got %b want %b", i, ready, (i == 7));
        end
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL bounce_pulse_count got %0d want 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [3];
    logic [3:0] seen[$];
    codes[0] = 4'b0111; codes[1] = 4'b1101; codes[2] = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 20; i++) begin
        tick((i < 10) ? codes[c] : 4'b0000);
        if (btn_pulse != 0) seen.push_back(btn_pulse);
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick(4'b0000);
      if (btn_pulse != 0) seen.push_back(btn_pulse);
    end
    n_checks++;
    if (seen.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want 3", seen.size());
    end
    for (int c = 0; c < 3; c++) begin
      if (c < seen.size()) begin
        n_checks++;
        if (seen[c] !== codes[c]) begin
          n_fail++;
          $display("FAIL b2b_code idx=%0d got %b want %b", c, seen[c], codes[c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_press();
    int         hold [2];
    logic [3:0] key  [2];
    hold[0] = 4; key[0] = 4'b0011;   // still settling at reset
    hold[1] = 9; key[1] = 4'b1000;   // already accepted and held at reset
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < hold[c]; i++) tick(key[c]);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
        tick(key[c]);
        n_checks++;
        if (btn_pulse !== 4'b0000 || ready !== 1'b1 || pressed !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst_values case=%0d got %b/%b/%b want 0000/0/1", c, btn_pulse, pressed, ready);
        end
      end
      rst = 1'b0;
      for (int i = 1; i <= 12; i++) begin
        tick(key[c]);
        n_checks++;
        if (btn_pulse !== ((i == 7) ? key[c] : 4'b0000)) begin
          n_fail++;
          $display("FAIL midrst_pulse case=%0d tick=%0d got %b want %b", c, i, btn_pulse, (i == 7) ? key[c] : 4'b0000);
        end
      end
      for (int i = 0; i < 10; i++) tick(4'b0000);
    end
  endtask

  task automatic test_random();
    logic [3:0] prev_pulse = 0;
    int         since = 1000;
    int         len;
    logic [3:0] code;
    for (int seg = 0; seg < 200; seg++) begin
      code = 4'($urandom_range(0, 15));
      len  = $urandom_range(1, 12);
      rst  = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < len; i++) begin
        tick(code);
        if (rst) since = 1000;
        if (i == 1) rst = 1'b0;
        n_checks++;
        if ({btn_pulse, pressed, ready} !== {m_pulse, m_pressed, m_ready}) begin
          n_fail++;
          $display("FAIL rand_model seg=%0d got %b/%b/%b want %b/%b/%b", seg, btn_pulse, pressed, ready, m_pulse, m_pressed, m_ready);
        end
        if (btn_pulse != 0) begin
          n_checks++;
          if (prev_pulse != 0 || ready !== 1'b0 || since < 2 * D) begin
            n_fail++;
            $display("FAIL rand_pulse_rules seg=%0d prev=%b ready=%b gap=%0d want prev=0000 ready=0 gap>=%0d", seg, prev_pulse, ready, since, 2 * D);
          end
          since = 0;
        end else begin
          since++;
        end
        prev_pulse = btn_pulse;
      end
      rst = 1'b0;
    end
    for (int i = 0; i < 12; i++) tick(4'b0000);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rand_final_ready got %b want 1", ready);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_chord();
    test_release_bounce();
    test_back_to_back();
    test_reset_mid_press();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
